// File: rtl/max_pool_row_combiner.sv
// Vertical stage of a 2x2/stride-2 max-pool: buffers each even row, merges it lane-wise with the following odd row.
// Optional build macro MAX_POOL_RELU_EN clamps negative pooled lanes to zero (fused ReLU).
module max_pool_row_combiner #(
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_MODULES = 16,
  parameter int NUM_ROWS    = 26
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [DATA_WIDTH*2*NUM_MODULES-1:0] in_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [DATA_WIDTH*NUM_MODULES-1:0]   out_data,
  output logic                                frame_done
);

  localparam int LW   = DATA_WIDTH * 2;
  localparam int HALF = NUM_MODULES / 2;
  localparam int CW   = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

  typedef enum logic {
    S_EVEN = 1'b0,
    S_ODD  = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        row_cnt_q, row_cnt_d;
  logic [HALF*LW-1:0]   row_buf_q, row_buf_d;
  logic                 out_valid_q, out_valid_d;
  logic [HALF*LW-1:0]   out_data_q, out_data_d;
  logic                 frame_done_q, frame_done_d;

  logic [HALF*LW-1:0]   even_lanes;
  logic [HALF*LW-1:0]   odd_lanes;
  logic [HALF*LW-1:0]   pooled;
  logic                 last_row;
  logic                 unused_odd_lanes;

  // Only even lanes are kept; discarding the odd ones realises the horizontal stride.
  genvar gi;
  generate
    for (gi = 0; gi < HALF; gi++) begin : g_lane
      logic signed [LW-1:0] buf_lane;
      logic signed [LW-1:0] in_lane;
      logic signed [LW-1:0] max_lane;

      assign even_lanes[gi*LW +: LW] = in_data[(2*gi)*LW +: LW];
      assign odd_lanes[gi*LW +: LW]  = in_data[(2*gi+1)*LW +: LW];
      assign buf_lane = row_buf_q[gi*LW +: LW];
      assign in_lane  = in_data[(2*gi)*LW +: LW];
      assign max_lane = (in_lane > buf_lane) ? in_lane : buf_lane;

`ifdef MAX_POOL_RELU_EN
      assign pooled[gi*LW +: LW] = max_lane[LW-1] ? '0 : max_lane;
`else
      assign pooled[gi*LW +: LW] = max_lane;
`endif
    end
  endgenerate

  assign unused_odd_lanes = ^odd_lanes;
  assign last_row         = (row_cnt_q == CW'(NUM_ROWS - 1));

  always_comb begin
    state_d      = state_q;
    row_cnt_d    = row_cnt_q;
    row_buf_d    = row_buf_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    frame_done_d = 1'b0;
    in_ready     = 1'b1;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      S_EVEN: begin
        in_ready = 1'b1;
        if (in_valid) begin
          // A trailing unpaired row in an odd-height frame closes the frame without output.
          if (last_row) begin
            frame_done_d = 1'b1;
            row_cnt_d    = '0;
          end else begin
            row_buf_d = even_lanes;
            row_cnt_d = row_cnt_q + CW'(1);
            state_d   = S_ODD;
          end
        end
      end

      S_ODD: begin
        in_ready = !out_valid_q || out_ready;
        if (in_valid && in_ready) begin
          out_data_d  = pooled;
          out_valid_d = 1'b1;
          state_d     = S_EVEN;
          if (last_row) begin
            frame_done_d = 1'b1;
            row_cnt_d    = '0;
          end else begin
            row_cnt_d = row_cnt_q + CW'(1);
          end
        end
      end

      default: begin
        state_d = S_EVEN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_EVEN;
      row_cnt_q    <= '0;
      row_buf_q    <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_cnt_q    <= row_cnt_d;
      row_buf_q    <= row_buf_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_max_pool_row_combiner.sv
// Self-checking bench for max_pool_row_combiner: directed steps plus random traffic against a row-level reference model.
module tb_max_pool_row_combiner;

  localparam int DW   = 8;
  localparam int NM   = 16;
  localparam int NR   = 5;
  localparam int LW   = DW * 2;
  localparam int HALF = NM / 2;
  localparam int IW   = LW * NM;
  localparam int OW   = DW * NM;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [IW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [OW-1:0] out_data;
  logic          frame_done;

  always #5 clk = ~clk;

  max_pool_row_combiner #(
    .DATA_WIDTH (DW),
    .NUM_MODULES(NM),
    .NUM_ROWS   (NR)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .frame_done(frame_done)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: position of the next row in the frame, the pending even row, expected outputs.
  int            idx = 0;
  logic [LW-1:0] held [HALF];
  logic [OW-1:0] exp_q [$];
  logic          fd_exp = 1'b0;

  task automatic chk(input string tag, input logic [IW-1:0] obs, input logic [IW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [OW-1:0] pool_ref(input logic [IW-1:0] d);
    logic [OW-1:0] r;
    int a, b, m;
    r = '0;
    for (int j = 0; j < HALF; j++) begin
      a = $signed(held[j]);
      b = $signed(d[2*j*LW +: LW]);
      m = (a > b) ? a : b;
`ifdef MAX_POOL_RELU_EN
      if (m < 0) m = 0;
`endif
      r[j*LW +: LW] = m[LW-1:0];
    end
    return r;
  endfunction

  task automatic model_accept(input logic [IW-1:0] d);
    if (idx % 2 == 0) begin
      if (idx == NR - 1) begin
        fd_exp = 1'b1;
        idx = 0;
      end else begin
        for (int j = 0; j < HALF; j++) held[j] = d[2*j*LW +: LW];
        idx++;
      end
    end else begin
      exp_q.push_back(pool_ref(d));
      if (idx == NR - 1) begin
        fd_exp = 1'b1;
        idx = 0;
      end else begin
        idx++;
      end
    end
  endtask

  function automatic logic [IW-1:0] rand_row();
    logic [IW-1:0] r;
    for (int k = 0; k < IW / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  // One clock: check handshake/outputs before the edge, update the model, check frame_done after.
  task automatic cycle(output bit accepted);
    logic acc_in, acc_out, exp_rdy;
    #1;
    exp_rdy = (idx % 2 == 0) || (exp_q.size() == 0) || out_ready;
    chk("in_ready", in_ready, exp_rdy);
    chk("out_valid", out_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) chk("out_data", out_data, exp_q[0]);
    acc_in  = in_valid && in_ready;
    acc_out = out_valid && out_ready;
    @(posedge clk);
    fd_exp = 1'b0;
    if (acc_out && exp_q.size() != 0) void'(exp_q.pop_front());
    if (acc_in) model_accept(in_data);
    #1;
    chk("frame_done", frame_done, fd_exp);
    @(negedge clk);
    accepted = acc_in;
    $display("t=%0t in_v=%0b in_r=%0b out_v=%0b out_r=%0b fd=%0b row_idx=%0d pending=%0d",
             $time, in_valid, acc_in, out_valid, out_ready, frame_done, idx, exp_q.size());
  endtask

  task automatic send_row(input logic [IW-1:0] d, input string tag);
    bit acc;
    acc = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int n = 0; n < 20 && !acc; n++) cycle(acc);
    chk(tag, acc, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bit acc;
    in_valid = 1'b0;
    for (int k = 0; k < n; k++) cycle(acc);
  endtask

  task automatic do_reset(input int n);
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_data  = rand_row();
    repeat (n) @(posedge clk);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    idx      = 0;
    fd_exp   = 1'b0;
    exp_q.delete();
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, '0);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [IW-1:0] r0, r1;
    logic [OW-1:0] lit;
    bit acc;

    do_reset(2);

    // Basic pair: lanes i and 20-i.
    out_ready = 1'b1;
    for (int i = 0; i < NM; i++) begin
      r0[i*LW +: LW] = LW'(i);
      r1[i*LW +: LW] = LW'(20 - i);
    end
    send_row(r0, "basic_row0");
    send_row(r1, "basic_row1");
    lit = 128'h000E_000C_000A_000C_000E_0010_0012_0014;
    chk("basic_pooled", out_data, lit);

    // Signed compare: -16 vs 5.
    r0 = rand_row();
    r0[0 +: LW] = 16'hFFF0;
    r1 = rand_row();
    r1[0 +: LW] = 16'h0005;
    send_row(r0, "signed_row2");
    send_row(r1, "signed_row3");
    chk("signed_lane0", out_data[LW-1:0], 16'h0005);

    // Odd frame tail: row 4 is dropped and closes the frame.
    send_row(rand_row(), "drop_row4");

    // Both negative: -3 vs -7, output held (out_ready low) for backpressure.
    out_ready = 1'b0;
    r0 = rand_row();
    r0[0 +: LW] = 16'hFFFD;
    r1 = rand_row();
    r1[0 +: LW] = 16'hFFF9;
    send_row(r0, "neg_row0");
    send_row(r1, "neg_row1");
`ifdef MAX_POOL_RELU_EN
    chk("neg_lane0", out_data[LW-1:0], 16'h0000);
`else
    chk("neg_lane0", out_data[LW-1:0], 16'hFFFD);
`endif

    // Backpressure: even row accepted, odd row stalls until the output drains.
    send_row(rand_row(), "bp_row2");
    in_valid = 1'b1;
    in_data  = rand_row();
    for (int k = 0; k < 3; k++) begin
      cycle(acc);
      chk("bp_stall", acc, 1'b0);
    end
    out_ready = 1'b1;
    cycle(acc);
    chk("bp_same_cycle_accept", acc, 1'b1);
    in_valid = 1'b0;
    chk("bp_no_bubble", out_valid, 1'b1);
    send_row(rand_row(), "bp_drop_row4");
    idle(2);

    // Reset mid-pair discards the buffered row.
    r0 = '1;
    send_row(r0, "midrst_row0");
    do_reset(1);
    send_row(rand_row(), "midrst_rowA");
    send_row(rand_row(), "midrst_rowB");
    idle(2);

    // Random traffic with random backpressure.
    for (int k = 0; k < 300; k++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      in_data   = rand_row();
      if (($urandom % 8) == 0) in_data[0 +: LW] = held[0];
      cycle(acc);
    end
    out_ready = 1'b1;
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
